// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline requesters, the arbiter and the memory macro.
// master: the pipeline/memory side, slave: the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [2:0]        d_size;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [2:0]        mem_size;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata, d_size,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_size,
    input  busy
  );

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata, d_size,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_size,
    output busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the fetch and data ports,
// one transaction in flight, data priority bounded by a starvation counter.
module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input logic          clk,
  input logic          rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [2:0] LAST = 3'(MEM_LAT - 1);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  localparam logic [2:0] FETCH_SIZE = 3'b010;

  state_t     state;
  logic [2:0] lat_cnt;
  logic [3:0] starve_cnt;
  logic       own_d;
  logic       own_we;

  logic resp;
  logic issue;
  logic pick_d;
  logic if_gnt;
  logic d_gnt;

  assign resp   = (state == WAIT) && (lat_cnt == LAST);
  assign issue  = !rst && (state == IDLE || resp)
                  && (bus.if_req || bus.d_req);
  assign pick_d = bus.d_req
                  && !(bus.if_req && starve_cnt == SMAX);
  assign if_gnt = issue && !pick_d;
  assign d_gnt  = issue && pick_d;

  assign bus.if_gnt = if_gnt;
  assign bus.d_gnt  = d_gnt;
  assign bus.mem_en = issue;
  assign bus.mem_we = d_gnt && bus.d_we;
  assign bus.busy   = (state == WAIT);

  assign bus.if_rvalid = resp && !own_d;
  assign bus.d_rvalid  = resp && own_d;
  assign bus.if_rdata  = (resp && !own_d)
                         ? bus.mem_rdata : {DATA_W{1'b0}};
  // Stores complete with a zero data word.
  assign bus.d_rdata   = (resp && own_d && !own_we)
                         ? bus.mem_rdata : {DATA_W{1'b0}};

  always_comb begin
    bus.mem_addr  = {ADDR_W{1'b0}};
    bus.mem_wdata = {DATA_W{1'b0}};
    bus.mem_size  = 3'b000;
    unique case (1'b1)
      d_gnt: begin
        bus.mem_addr  = bus.d_addr;
        bus.mem_wdata = bus.d_wdata;
        bus.mem_size  = bus.d_size;
      end
      if_gnt: begin
        bus.mem_addr = bus.if_addr;
        bus.mem_size = FETCH_SIZE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lat_cnt    <= 3'd0;
      starve_cnt <= 4'd0;
      own_d      <= 1'b0;
      own_we     <= 1'b0;
    end else begin
      if (issue) begin
        state   <= WAIT;
        lat_cnt <= 3'd0;
        own_d   <= pick_d;
        own_we  <= pick_d && bus.d_we;
      end else if (resp) begin
        state   <= IDLE;
        lat_cnt <= 3'd0;
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt + 3'd1;
      end
      if (!bus.if_req || if_gnt)
        starve_cnt <= 4'd0;
      else if (d_gnt && starve_cnt != SMAX)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 with MEM_LAT=1, instance 1 with
// MEM_LAT=3, each against a behavioural memory and transaction model.
module tb_mem_port_arbiter;

  localparam int SMAX = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        if_req  [2];
  logic [7:0]  if_addr [2];
  logic        d_req   [2];
  logic        d_we    [2];
  logic [7:0]  d_addr  [2];
  logic [31:0] d_wdata [2];
  logic [2:0]  d_size  [2];

  logic        o_if_gnt    [2];
  logic        o_if_rvalid [2];
  logic [31:0] o_if_rdata  [2];
  logic        o_d_gnt     [2];
  logic        o_d_rvalid  [2];
  logic [31:0] o_d_rdata   [2];
  logic        o_mem_en    [2];
  logic        o_mem_we    [2];
  logic [7:0]  o_mem_addr  [2];
  logic [31:0] o_mem_wdata [2];
  logic [2:0]  o_mem_size  [2];
  logic        o_busy      [2];

  logic [31:0] env_mem [2][256];
  logic [31:0] pipe    [2][7];
  logic        env_init = 1'b1;

  int lat [2];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int L = (g == 0) ? 1 : 3;
    mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();
    mem_port_arbiter #(
      .ADDR_W(8), .DATA_W(32), .MEM_LAT(L), .STARVE_MAX(SMAX)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
    assign bus.if_req    = if_req[g];
    assign bus.if_addr   = if_addr[g];
    assign bus.d_req     = d_req[g];
    assign bus.d_we      = d_we[g];
    assign bus.d_addr    = d_addr[g];
    assign bus.d_wdata   = d_wdata[g];
    assign bus.d_size    = d_size[g];
    assign bus.mem_rdata = pipe[g][L-1];
    assign o_if_gnt[g]    = bus.if_gnt;
    assign o_if_rvalid[g] = bus.if_rvalid;
    assign o_if_rdata[g]  = bus.if_rdata;
    assign o_d_gnt[g]     = bus.d_gnt;
    assign o_d_rvalid[g]  = bus.d_rvalid;
    assign o_d_rdata[g]   = bus.d_rdata;
    assign o_mem_en[g]    = bus.mem_en;
    assign o_mem_we[g]    = bus.mem_we;
    assign o_mem_addr[g]  = bus.mem_addr;
    assign o_mem_wdata[g] = bus.mem_wdata;
    assign o_mem_size[g]  = bus.mem_size;
    assign o_busy[g]      = bus.busy;
  end

  function automatic logic [31:0] init_word(input int a);
    case (a)
      4:       return 32'h0050_0093;
      8:       return 32'h0000_0013;
      'h40:    return 32'hDEAD_BEEF;
      default: return {24'h5A5A5A, 8'(a)};
    endcase
  endfunction

  // Memory macro: sampled at the edge after issue, data valid MEM_LAT cycles later.
  always @(posedge clk) begin
    env_init <= 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (env_init) begin
        for (int a = 0; a < 256; a++) env_mem[k][a] <= init_word(a);
      end else if (o_mem_en[k] && o_mem_we[k]) begin
        env_mem[k][o_mem_addr[k]] <= o_mem_wdata[k];
      end
      pipe[k][0] <= o_mem_en[k] ? env_mem[k][o_mem_addr[k]] : 32'hBADC_0DE5;
      for (int i = 1; i < 7; i++) pipe[k][i] <= pipe[k][i-1];
    end
  end

  // Transaction-level reference model.
  logic [31:0] mm [2][256];
  logic        m_out  [2];
  int          m_due  [2];
  logic        m_d    [2];
  logic        m_we   [2];
  logic [31:0] m_data [2];
  int          st     [2];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_cycle(input int k);
    logic        resp, iss, wd, eig, edg;
    logic [7:0]  eaddr;
    logic [31:0] ewd;
    logic [2:0]  esz;
    string       p;
    p = $sformatf("k%0d ", k);
    if (rst) begin
      m_out[k] = 1'b0;
      st[k] = 0;
      resp = 1'b0;
      iss = 1'b0;
      wd = 1'b0;
    end else begin
      resp = m_out[k] && (cyc == m_due[k]);
      iss  = (!m_out[k] || resp) && (if_req[k] || d_req[k]);
      wd   = d_req[k] && !(if_req[k] && st[k] == SMAX);
    end
    eig   = iss && !wd;
    edg   = iss && wd;
    eaddr = edg ? d_addr[k] : (eig ? if_addr[k] : 8'h00);
    ewd   = edg ? d_wdata[k] : 32'h0;
    esz   = edg ? d_size[k] : (eig ? 3'b010 : 3'b000);
    chk({p, "if_gnt"},    32'(o_if_gnt[k]),    32'(eig));
    chk({p, "d_gnt"},     32'(o_d_gnt[k]),     32'(edg));
    chk({p, "mem_en"},    32'(o_mem_en[k]),    32'(iss));
    chk({p, "mem_we"},    32'(o_mem_we[k]),    32'(edg && d_we[k]));
    chk({p, "mem_addr"},  32'(o_mem_addr[k]),  32'(eaddr));
    chk({p, "mem_wdata"}, o_mem_wdata[k],      ewd);
    chk({p, "mem_size"},  32'(o_mem_size[k]),  32'(esz));
    chk({p, "busy"},      32'(o_busy[k]),      32'(!rst && m_out[k]));
    chk({p, "if_rvalid"}, 32'(o_if_rvalid[k]), 32'(resp && !m_d[k]));
    chk({p, "if_rdata"},  o_if_rdata[k],
        (resp && !m_d[k]) ? m_data[k] : 32'h0);
    chk({p, "d_rvalid"},  32'(o_d_rvalid[k]),  32'(resp && m_d[k]));
    chk({p, "d_rdata"},   o_d_rdata[k],
        (resp && m_d[k]) ? m_data[k] : 32'h0);
    if (rst) return;
    if (resp) m_out[k] = 1'b0;
    if (iss) begin
      m_out[k]  = 1'b1;
      m_due[k]  = cyc + lat[k];
      m_d[k]    = wd;
      m_we[k]   = wd && d_we[k];
      m_data[k] = (wd && d_we[k]) ? 32'h0 : mm[k][eaddr];
      if (wd && d_we[k]) mm[k][eaddr] = d_wdata[k];
    end
    if (!if_req[k] || eig) st[k] = 0;
    else if (edg && st[k] < SMAX) st[k] = st[k] + 1;
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) model_cycle(k);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  logic [7:0] gseq;

  initial begin
    lat[0] = 1;
    lat[1] = 3;
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 256; a++) mm[k][a] = init_word(a);
      m_out[k] = 1'b0; m_due[k] = 0; m_d[k] = 1'b0; m_we[k] = 1'b0;
      m_data[k] = 32'h0; st[k] = 0;
      if_req[k] = 1'b0; if_addr[k] = 8'h00;
      d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = 8'h00;
      d_wdata[k] = 32'h0; d_size[k] = 3'b010;
    end
    rst = 1'b1;
    if_req[0] = 1'b1;
    at_neg();
    chk("reset if_gnt", 32'(o_if_gnt[0]), 32'h0);
    chk("reset busy", 32'(o_busy[0]), 32'h0);
    step();
    if_req[0] = 1'b0;
    step();
    rst = 1'b0;
    step();

    // single fetch, MEM_LAT=1
    if_req[0] = 1'b1; if_addr[0] = 8'h04;
    at_neg();
    chk("t1 if_gnt", 32'(o_if_gnt[0]), 32'h1);
    chk("t1 mem_addr", 32'(o_mem_addr[0]), 32'h04);
    chk("t1 busy n", 32'(o_busy[0]), 32'h0);
    step();
    if_req[0] = 1'b0;
    at_neg();
    chk("t1 if_rvalid", 32'(o_if_rvalid[0]), 32'h1);
    chk("t1 if_rdata", o_if_rdata[0], 32'h0050_0093);
    chk("t1 busy n+1", 32'(o_busy[0]), 32'h1);
    step();
    at_neg();
    chk("t1 busy n+2", 32'(o_busy[0]), 32'h0);
    step();

    // simultaneous fetch and load
    if_req[0] = 1'b1; if_addr[0] = 8'h08;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 8'h40;
    at_neg();
    chk("t2 d_gnt", 32'(o_d_gnt[0]), 32'h1);
    chk("t2 if_gnt n", 32'(o_if_gnt[0]), 32'h0);
    step();
    d_req[0] = 1'b0;
    at_neg();
    chk("t2 d_rdata", o_d_rdata[0], 32'hDEAD_BEEF);
    chk("t2 if_gnt n+1", 32'(o_if_gnt[0]), 32'h1);
    step();
    if_req[0] = 1'b0;
    at_neg();
    chk("t2 if_rdata", o_if_rdata[0], 32'h0000_0013);
    step();

    // starvation bound with both ports saturated
    if_req[0] = 1'b1; if_addr[0] = 8'h0C;
    d_req[0] = 1'b1; d_addr[0] = 8'h44;
    for (int i = 0; i < 8; i++) begin
      at_neg();
      gseq[i] = o_d_gnt[0];
      step();
    end
    if_req[0] = 1'b0; d_req[0] = 1'b0;
    chk("t3 grant seq", 32'(gseq), 32'h77);
    step();

    // store then load of the same word
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 8'h20;
    d_wdata[0] = 32'h1234_5678; d_size[0] = 3'b010;
    at_neg();
    chk("t4 mem_we", 32'(o_mem_we[0]), 32'h1);
    chk("t4 mem_wdata", o_mem_wdata[0], 32'h1234_5678);
    chk("t4 mem_size", 32'(o_mem_size[0]), 32'h2);
    step();
    d_we[0] = 1'b0; d_wdata[0] = 32'h0;
    at_neg();
    chk("t4 st d_rvalid", 32'(o_d_rvalid[0]), 32'h1);
    chk("t4 st d_rdata", o_d_rdata[0], 32'h0);
    step();
    d_req[0] = 1'b0;
    at_neg();
    chk("t4 ld d_rdata", o_d_rdata[0], 32'h1234_5678);
    step();

    // MEM_LAT=3 blocks issue until the response cycle
    if_req[1] = 1'b1; if_addr[1] = 8'h04;
    at_neg();
    chk("t5 if_gnt", 32'(o_if_gnt[1]), 32'h1);
    step();
    if_req[1] = 1'b0;
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 8'h40;
    at_neg();
    chk("t5 d_gnt n+1", 32'(o_d_gnt[1]), 32'h0);
    step();
    at_neg();
    chk("t5 d_gnt n+2", 32'(o_d_gnt[1]), 32'h0);
    step();
    at_neg();
    chk("t5 d_gnt n+3", 32'(o_d_gnt[1]), 32'h1);
    chk("t5 if_rdata", o_if_rdata[1], 32'h0050_0093);
    step();
    d_req[1] = 1'b0;
    step();
    step();
    at_neg();
    chk("t5 d_rdata", o_d_rdata[1], 32'hDEAD_BEEF);
    step();

    // reset in the middle of a MEM_LAT=3 load
    d_req[1] = 1'b1; d_addr[1] = 8'h40;
    at_neg();
    chk("t6 d_gnt", 32'(o_d_gnt[1]), 32'h1);
    step();
    d_req[1] = 1'b0;
    rst = 1'b1;
    if_req[0] = 1'b1; if_addr[0] = 8'h04;
    at_neg();
    chk("t6 busy rst", 32'(o_busy[1]), 32'h0);
    chk("t6 if_gnt rst", 32'(o_if_gnt[0]), 32'h0);
    step();
    step();
    rst = 1'b0;
    if_req[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      at_neg();
      chk("t6 no d_rvalid", 32'(o_d_rvalid[1]), 32'h0);
      step();
    end
    if_req[1] = 1'b1; if_addr[1] = 8'h04;
    at_neg();
    chk("t6 post if_gnt", 32'(o_if_gnt[1]), 32'h1);
    step();
    if_req[1] = 1'b0;
    step();
    step();
    at_neg();
    chk("t6 post if_rdata", o_if_rdata[1], 32'h0050_0093);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
